rgb2gray_stream: RTL and testbench

Pipelined, parametrised RGB-to-grayscale converter with a valid/ready streaming interface. It sits at the head of the image-processing chain, between the pixel source and the salt-and-pepper denoise / edge-detection stages. It generalises the fixed 8-bit combinational BT.601 converter in four ways: configurable channel and output widths, a per-pixel coefficient mode, sideband pass-through, and backpressure-aware registered stages.

---
 rtl/rgb2gray_stream.sv | 100 ++++++++++
 tb/tb_rgb2gray_stream.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rgb2gray_stream.sv
// rgb2gray_stream: three-stage RGB to luma converter with valid/ready flow.
// Per-pixel coefficient mode, sideband pass-through, bubble-collapsing stalls.
module rgb2gray_stream #(
  parameter int CW = 8,
  parameter int OW = 8,
  parameter int UW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3*CW-1:0] in_rgb,
  input  logic [1:0]      in_mode,
  input  logic [UW-1:0]   in_user,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_y,
  output logic [UW-1:0]   out_user
);

  localparam int SW = CW + 9;
  localparam int SH = 8 + CW - OW;
  localparam logic [SW-1:0] RND  = SW'(1) << (SH - 1);
  localparam logic [SW-1:0] YMAX = (SW'(1) << OW) - SW'(1);

  logic          v1, v2, v3;
  logic          adv1, adv2, adv3;
  logic [SW-1:0] pr1, pg1, pb1;
  logic [SW-1:0] s2;
  logic [UW-1:0] u1, u2;

  logic [CW-1:0] r, g, b;
  logic [8:0]    kr, kg, kb;
  logic [SW-1:0] pr_d, pg_d, pb_d;
  logic [SW-1:0] ysh;
  logic [OW-1:0] y_d;

  assign {r, g, b} = in_rgb;

  always_comb begin
    kr = 9'd77;
    kg = 9'd150;
    kb = 9'd29;
    unique case (in_mode)
      2'd0: begin kr = 9'd77; kg = 9'd150; kb = 9'd29; end
      2'd1: begin kr = 9'd54; kg = 9'd183; kb = 9'd19; end
      2'd2: begin kr = 9'd85; kg = 9'd86;  kb = 9'd85; end
      2'd3: begin kr = 9'd0;  kg = 9'd256; kb = 9'd0;  end
    endcase
  end

  // Coefficients sum to 256, so every product and the sum fit in CW+9 bits.
  assign pr_d = SW'(kr) * SW'(r);
  assign pg_d = SW'(kg) * SW'(g);
  assign pb_d = SW'(kb) * SW'(b);

  assign ysh = s2 >> SH;
  assign y_d = (ysh > YMAX) ? {OW{1'b1}} : ysh[OW-1:0];

  assign adv3      = !v3 | out_ready;
  assign adv2      = !v2 | adv3;
  assign adv1      = !v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      pr1      <= '0;
      pg1      <= '0;
      pb1      <= '0;
      s2       <= '0;
      u1       <= '0;
      u2       <= '0;
      out_y    <= '0;
      out_user <= '0;
    end else begin
      if (adv1) begin
        v1  <= in_valid & in_ready;
        pr1 <= pr_d;
        pg1 <= pg_d;
        pb1 <= pb_d;
        u1  <= in_user;
      end
      if (adv2) begin
        v2 <= v1;
        s2 <= pr1 + pg1 + pb1 + RND;
        u2 <= u1;
      end
      if (adv3) begin
        v3       <= v2;
        out_y    <= y_d;
        out_user <= u2;
      end
    end
  end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb_rgb2gray_stream: directed checks of rgb2gray_stream.
// Default instance plus a CW=10/OW=9 instance for saturation.
module tb_rgb2gray_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_rgb;
  logic [1:0]  in_mode, in_user, out_user;
  logic [7:0]  out_y;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [29:0] in_rgb2;
  logic [1:0]  in_mode2, in_user2, out_user2;
  logic [8:0]  out_y2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rgb2gray_stream dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rgb(in_rgb), .in_mode(in_mode), .in_user(in_user),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_user(out_user)
  );

  rgb2gray_stream #(.CW(10), .OW(9), .UW(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_rgb(in_rgb2), .in_mode(in_mode2), .in_user(in_user2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_y(out_y2), .out_user(out_user2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, g, b,
                       input logic [1:0] m, input logic [1:0] u);
    in_valid = v;
    in_rgb   = {r, g, b};
    in_mode  = m;
    in_user  = u;
  endtask

  logic [7:0] tr [5];
  logic [7:0] tg [5];
  logic [7:0] tb [5];
  logic [7:0] ty [5];
  logic [1:0] tu [5];

  initial begin
    int ai, ri;
    logic acc;
    tr = '{8'd100, 8'd0,   8'd0,   8'd10, 8'd200};
    tg = '{8'd100, 8'd0,   8'd255, 8'd20, 8'd100};
    tb = '{8'd100, 8'd255, 8'd0,   8'd30, 8'd50};
    ty = '{8'd100, 8'd29,  8'd149, 8'd18, 8'd124};
    tu = '{2'd0,   2'd1,   2'd2,   2'd3,  2'd0};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 2'd0);
    in_valid2 = 1'b0; in_rgb2 = '0; in_mode2 = 2'd0;
    in_user2 = 2'd0; out_ready2 = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_user", 32'(out_user), 0);
    rst = 1'b0;
    #1 chk("rst_ready", 32'(in_ready), 1);

    // Test 1: BT.601, back-to-back
    drive(1'b1, 8'd255, 8'd255, 8'd255, 2'd0, 2'd1);
    tick();
    drive(1'b1, 8'd255, 8'd0, 8'd0, 2'd0, 2'd2);
    tick();
    in_valid = 1'b0;
    chk("t1_lat_early", 32'(out_valid), 0);
    tick();
    chk("t1_v0", 32'(out_valid), 1);
    chk("t1_y0", 32'(out_y), 255);
    chk("t1_u0", 32'(out_user), 1);
    tick();
    chk("t1_v1", 32'(out_valid), 1);
    chk("t1_y1", 32'(out_y), 77);
    chk("t1_u1", 32'(out_user), 2);
    tick();
    chk("t1_empty", 32'(out_valid), 0);

    // Test 2: per-pixel mode switching
    drive(1'b1, 8'd0, 8'd255, 8'd0, 2'd1, 2'd1);
    tick();
    drive(1'b1, 8'd30, 8'd60, 8'd90, 2'd2, 2'd2);
    tick();
    drive(1'b1, 8'd17, 8'd200, 8'd99, 2'd3, 2'd3);
    tick();
    in_valid = 1'b0;
    chk("t2_y709", 32'(out_y), 182);
    chk("t2_u709", 32'(out_user), 1);
    tick();
    chk("t2_yavg", 32'(out_y), 60);
    chk("t2_uavg", 32'(out_user), 2);
    tick();
    chk("t2_ygrn", 32'(out_y), 200);
    chk("t2_vgrn", 32'(out_valid), 1);
    tick();
    chk("t2_empty", 32'(out_valid), 0);

    // Test 3: backpressure with scoreboard table
    out_ready = 1'b0;
    ai = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, tr[ai], tg[ai], tb[ai], 2'd0, tu[ai]);
      #1 acc = in_valid & in_ready;
      tick();
      if (acc) ai++;
    end
    drive(1'b1, tr[ai], tg[ai], tb[ai], 2'd0, tu[ai]);
    #1;
    chk("t3_full_ready", 32'(in_ready), 0);
    chk("t3_accepted", 32'(ai), 3);
    chk("t3_hold_y", 32'(out_y), 100);
    tick();
    chk("t3_stable_y", 32'(out_y), 100);
    chk("t3_stable_v", 32'(out_valid), 1);
    out_ready = 1'b1;
    ri = 0;
    for (int c = 0; c < 20 && ri < 5; c++) begin
      if (ai < 5) drive(1'b1, tr[ai], tg[ai], tb[ai], 2'd0, tu[ai]);
      else in_valid = 1'b0;
      #1;
      if (out_valid) begin
        chk("t3_y", 32'(out_y), 32'(ty[ri]));
        chk("t3_u", 32'(out_user), 32'(tu[ri]));
        ri++;
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) ai++;
    end
    in_valid = 1'b0;
    chk("t3_received", 32'(ri), 5);
    chk("t3_sent", 32'(ai), 5);
    chk("t3_no_dup", 32'(out_valid), 0);

    // Test 4: bubble collapse
    tick();
    out_ready = 1'b0;
    drive(1'b1, 8'd50, 8'd50, 8'd50, 2'd0, 2'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("t4_v3", 32'(out_valid), 1);
    chk("t4_ready", 32'(in_ready), 1);
    drive(1'b1, 8'd60, 8'd60, 8'd60, 2'd0, 2'd2);
    tick();
    drive(1'b1, 8'd70, 8'd70, 8'd70, 2'd0, 2'd3);
    #1 chk("t4_ready2", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    #1 chk("t4_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1 chk("t4_ya", 32'(out_y), 50);
    tick();
    chk("t4_yb", 32'(out_y), 60);
    chk("t4_ub", 32'(out_user), 2);
    tick();
    chk("t4_yc", 32'(out_y), 70);
    chk("t4_uc", 32'(out_user), 3);
    tick();
    chk("t4_empty", 32'(out_valid), 0);

    // Test 5: CW=10, OW=9 saturation
    in_valid2 = 1'b1; in_rgb2 = {10'd1023, 10'd1023, 10'd1023};
    in_user2 = 2'd1;
    tick();
    in_rgb2 = {10'd512, 10'd512, 10'd512}; in_user2 = 2'd2;
    tick();
    in_valid2 = 1'b0;
    tick();
    chk("t5_sat", 32'(out_y2), 511);
    chk("t5_sat_u", 32'(out_user2), 1);
    tick();
    chk("t5_half", 32'(out_y2), 256);
    chk("t5_half_v", 32'(out_valid2), 1);

    // Test 6: reset mid-stream
    drive(1'b1, 8'd10, 8'd10, 8'd10, 2'd0, 2'd1);
    tick(); tick(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_y", 32'(out_y), 0);
    chk("t6_ready", 32'(in_ready), 1);
    rst = 1'b0;
    tick();
    chk("t6_flushed", 32'(out_valid), 0);
    drive(1'b1, 8'd255, 8'd0, 8'd0, 2'd0, 2'd3);
    tick();
    in_valid = 1'b0;
    tick();
    chk("t6_early", 32'(out_valid), 0);
    tick();
    chk("t6_v", 32'(out_valid), 1);
    chk("t6_y2", 32'(out_y), 77);
    chk("t6_u", 32'(out_user), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
